// File: rtl/icache_data_ram_nway_pkg.sv
// Shared definitions for the N-way icache data store.
// Contents: refill FSM state encoding and the way-select width helper.
package icache_data_ram_nway_pkg;

   // Refill sequencer states.
   typedef enum logic [1:0] {
      REFILL_IDLE = 2'd0,
      REFILL_FILL = 2'd1,
      REFILL_DONE = 2'd2
   } refill_state_e;

   // Way-select width: log2(ways), never narrower than one bit.
   function automatic int unsigned way_bits(input int unsigned ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/icache_data_bank.sv
// One way of the icache data store: synchronous-read RAM, write-first on
// same-address collision, read register holds its value when not enabled.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (read register only)
//   rd_en, rd_addr      read request and word address
//   rd_data             registered read data
//   wr_en, wr_addr,
//   wr_data             single-word write
module icache_data_bank #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 11
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Storage array, never reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   // Read register; a same-cycle write to the read address is forwarded.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
      end
   end

endmodule

// File: rtl/icache_data_ram_nway.sv
// N-way instruction-cache data store.
// Read side returns every way of one (set, word) so the hit logic can pick one.
// Write side accepts a line refill as WORDS_PER_LINE valid/ready beats,
// starting at the critical word and wrapping within the line.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   rd_req_i, rd_index_i, rd_offset_i  read request
//   rd_valid_o, rd_data_o              read response, way w at [w*DATA_W +: DATA_W]
//   refill_start_i, refill_way_i,
//   refill_index_i, refill_offset_i    refill command (taken only when !busy_o)
//   refill_valid_i, refill_data_i,
//   refill_ready_o                     refill beat handshake
//   refill_done_o                      one-cycle pulse after the last beat
//   busy_o                             refill in progress
module icache_data_ram_nway
   import icache_data_ram_nway_pkg::*;
#(
   parameter int unsigned WAYS           = 2,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned INDEX_W        = 8,
   parameter int unsigned WORDS_PER_LINE = 8,
   parameter bit          OUT_REG        = 1'b0,
   localparam int unsigned OFFSET_W      = $clog2(WORDS_PER_LINE),
   localparam int unsigned WAY_W         = way_bits(WAYS)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     rd_req_i,
   input  logic [INDEX_W-1:0]       rd_index_i,
   input  logic [OFFSET_W-1:0]      rd_offset_i,
   output logic                     rd_valid_o,
   output logic [WAYS*DATA_W-1:0]   rd_data_o,
   input  logic                     refill_start_i,
   input  logic [WAY_W-1:0]         refill_way_i,
   input  logic [INDEX_W-1:0]       refill_index_i,
   input  logic [OFFSET_W-1:0]      refill_offset_i,
   input  logic                     refill_valid_i,
   input  logic [DATA_W-1:0]        refill_data_i,
   output logic                     refill_ready_o,
   output logic                     refill_done_o,
   output logic                     busy_o
);

   localparam int unsigned ADDR_W = INDEX_W + OFFSET_W;
   localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(WORDS_PER_LINE - 1);

   refill_state_e        state_q, state_d;
   logic [WAY_W-1:0]     way_q, way_d;
   logic [INDEX_W-1:0]   index_q, index_d;
   logic [OFFSET_W-1:0]  ptr_q, ptr_d;
   logic [OFFSET_W-1:0]  cnt_q, cnt_d;
   logic                 beat_acc;
   logic                 ready_q, done_q, busy_q;
   logic                 wr_en;
   logic                 rd_v1_q;
   logic [WAYS*DATA_W-1:0] bank_data;

   // Refill sequencer: next state, latched line context and beat bookkeeping.
   always_comb begin
      state_d  = state_q;
      way_d    = way_q;
      index_d  = index_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      beat_acc = 1'b0;
      unique case (state_q)
         REFILL_IDLE: begin
            if (refill_start_i) begin
               state_d = REFILL_FILL;
               way_d   = refill_way_i;
               index_d = refill_index_i;
               ptr_d   = refill_offset_i;
               cnt_d   = '0;
            end
         end
         REFILL_FILL: begin
            if (refill_valid_i) begin
               beat_acc = 1'b1;
               ptr_d    = ptr_q + OFFSET_W'(1);
               cnt_d    = cnt_q + OFFSET_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = REFILL_DONE;
               end
            end
         end
         REFILL_DONE: begin
            state_d = REFILL_IDLE;
         end
         default: begin
            state_d = REFILL_IDLE;
         end
      endcase
   end

   // Sequencer registers; handshake outputs are registered from the next state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= REFILL_IDLE;
         way_q   <= '0;
         index_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         way_q   <= way_d;
         index_q <= index_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         ready_q <= (state_d == REFILL_FILL);
         done_q  <= (state_d == REFILL_DONE);
         busy_q  <= (state_d != REFILL_IDLE);
      end
   end

   assign refill_ready_o = ready_q;
   assign refill_done_o  = done_q;
   assign busy_o         = busy_q;

   // A beat presented in the reset cycle is dropped.
   assign wr_en = beat_acc & ~rst_i;

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_data_bank #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .rd_en   (rd_req_i),
         .rd_addr ({rd_index_i, rd_offset_i}),
         .rd_data (bank_data[w*DATA_W +: DATA_W]),
         .wr_en   (wr_en && (way_q == WAY_W'(w))),
         .wr_addr ({index_q, ptr_q}),
         .wr_data (refill_data_i)
      );
   end

   // First read stage valid, aligned with the bank read register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_v1_q <= 1'b0;
      end else begin
         rd_v1_q <= rd_req_i;
      end
   end

   if (OUT_REG) begin : g_out_reg
      logic                   rd_v2_q;
      logic [WAYS*DATA_W-1:0] rd_d2_q;

      // Optional output stage; data only advances behind a valid read.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            rd_v2_q <= 1'b0;
            rd_d2_q <= '0;
         end else begin
            rd_v2_q <= rd_v1_q;
            if (rd_v1_q) begin
               rd_d2_q <= bank_data;
            end
         end
      end

      assign rd_valid_o = rd_v2_q;
      assign rd_data_o  = rd_d2_q;
   end else begin : g_no_out_reg
      assign rd_valid_o = rd_v1_q;
      assign rd_data_o  = bank_data;
   end

endmodule

// File: tb/tb_icache_data_ram_nway.sv
// Bench for icache_data_ram_nway: a 2-way single-stage instance and a 4-way
// instance with the output register, driven in lockstep and checked against
// a word-level memory model plus a queue of pending refill offsets.
module tb_icache_data_ram_nway;

   logic        clk_i;
   logic        rst_i;
   logic        rd_req;
   logic [7:0]  rd_index;
   logic [2:0]  rd_offset;
   logic        refill_start;
   logic [1:0]  refill_way;
   logic [7:0]  refill_index;
   logic [2:0]  refill_offset;
   logic        refill_valid;
   logic [31:0] refill_data;

   logic         a_rd_valid, a_ready, a_done, a_busy;
   logic [63:0]  a_rd_data;
   logic         b_rd_valid, b_ready, b_done, b_busy;
   logic [127:0] b_rd_data;

   icache_data_ram_nway #(
      .WAYS(2), .DATA_W(32), .INDEX_W(8), .WORDS_PER_LINE(8), .OUT_REG(1'b0)
   ) dut_a (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_req_i(rd_req), .rd_index_i(rd_index), .rd_offset_i(rd_offset),
      .rd_valid_o(a_rd_valid), .rd_data_o(a_rd_data),
      .refill_start_i(refill_start), .refill_way_i(refill_way[0:0]),
      .refill_index_i(refill_index), .refill_offset_i(refill_offset),
      .refill_valid_i(refill_valid), .refill_data_i(refill_data),
      .refill_ready_o(a_ready), .refill_done_o(a_done), .busy_o(a_busy)
   );

   icache_data_ram_nway #(
      .WAYS(4), .DATA_W(32), .INDEX_W(8), .WORDS_PER_LINE(8), .OUT_REG(1'b1)
   ) dut_b (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_req_i(rd_req), .rd_index_i(rd_index), .rd_offset_i(rd_offset),
      .rd_valid_o(b_rd_valid), .rd_data_o(b_rd_data),
      .refill_start_i(refill_start), .refill_way_i(refill_way),
      .refill_index_i(refill_index), .refill_offset_i(refill_offset),
      .refill_valid_i(refill_valid), .refill_data_i(refill_data),
      .refill_ready_o(b_ready), .refill_done_o(b_done), .busy_o(b_busy)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Word-level model: written data and a known flag per word.
   logic [31:0] m0 [2][256][8];
   bit          k0 [2][256][8];
   logic [31:0] m1 [4][256][8];
   bit          k1 [4][256][8];

   // Offsets still to be written for the line in flight, in beat order.
   int fill_q[$];
   int cur_way, cur_idx;

   bit exp_ready, exp_busy, exp_done;
   bit exp_av, exp_bv;
   logic [63:0]  exp_ad;
   bit   [1:0]   exp_akn;
   logic [127:0] exp_bd;
   bit   [3:0]   exp_bkn;
   bit           b_p_v;
   logic [127:0] b_p_d;
   bit   [3:0]   b_p_kn;

   int rand_rd = 0;   // 0: caller drives reads, 1: random reads, 2: read every cycle

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock: evaluate the model for this cycle, clock, then compare.
   task automatic step();
      bit acc, last, rdq;
      int off;
      logic [63:0]  rv0;
      bit   [1:0]   kn0;
      logic [127:0] rv1;
      bit   [3:0]   kn1;
      if (rand_rd != 0) begin
         rd_req    = (rand_rd == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
         rd_index  = 8'($urandom_range(0, 7));
         rd_offset = 3'($urandom_range(0, 7));
      end
      acc  = refill_valid && exp_ready && !rst_i;
      last = 1'b0;
      if (acc) begin
         off = fill_q.pop_front();
         m0[cur_way % 2][cur_idx][off] = refill_data;
         k0[cur_way % 2][cur_idx][off] = 1'b1;
         m1[cur_way][cur_idx][off]     = refill_data;
         k1[cur_way][cur_idx][off]     = 1'b1;
         last = (fill_q.size() == 0);
      end
      rdq = rd_req && !rst_i;
      rv0 = '0; kn0 = '0; rv1 = '0; kn1 = '0;
      for (int w = 0; w < 2; w++) begin
         rv0[w*32 +: 32] = m0[w][rd_index][rd_offset];
         kn0[w]          = k0[w][rd_index][rd_offset];
      end
      for (int w = 0; w < 4; w++) begin
         rv1[w*32 +: 32] = m1[w][rd_index][rd_offset];
         kn1[w]          = k1[w][rd_index][rd_offset];
      end
      if (!rst_i && !exp_busy && refill_start) begin
         cur_way = int'(refill_way);
         cur_idx = int'(refill_index);
         fill_q.delete();
         for (int k = 0; k < 8; k++) fill_q.push_back((int'(refill_offset) + k) % 8);
      end

      @(posedge clk_i);
      #1;

      if (rst_i) begin
         fill_q.delete();
         exp_ready = 0; exp_busy = 0; exp_done = 0;
         exp_av = 0; exp_ad = '0; exp_akn = '1;
         exp_bv = 0; exp_bd = '0; exp_bkn = '1; b_p_v = 0;
      end else begin
         exp_done  = last;
         exp_ready = (fill_q.size() != 0);
         exp_busy  = exp_ready || last;
         exp_av    = rdq;
         if (rdq) begin exp_ad = rv0; exp_akn = kn0; end
         exp_bv = b_p_v;
         if (b_p_v) begin exp_bd = b_p_d; exp_bkn = b_p_kn; end
         b_p_v = rdq;
         if (rdq) begin b_p_d = rv1; b_p_kn = kn1; end
      end

      chk("a_ready", 128'(a_ready), 128'(exp_ready));
      chk("a_busy",  128'(a_busy),  128'(exp_busy));
      chk("a_done",  128'(a_done),  128'(exp_done));
      chk("a_rd_valid", 128'(a_rd_valid), 128'(exp_av));
      chk("b_ready", 128'(b_ready), 128'(exp_ready));
      chk("b_busy",  128'(b_busy),  128'(exp_busy));
      chk("b_done",  128'(b_done),  128'(exp_done));
      chk("b_rd_valid", 128'(b_rd_valid), 128'(exp_bv));
      for (int w = 0; w < 2; w++)
         if (exp_akn[w]) chk("a_rd_data", 128'(a_rd_data[w*32 +: 32]), 128'(exp_ad[w*32 +: 32]));
      for (int w = 0; w < 4; w++)
         if (exp_bkn[w]) chk("b_rd_data", 128'(b_rd_data[w*32 +: 32]), 128'(exp_bd[w*32 +: 32]));
   endtask

   // mode 0: back-to-back beats, 1: valid toggling 1,0,1,0..., 2: random gaps.
   // coll: issue a read of the critical word in the cycle of the first beat.
   task automatic refill(input int w, input int idx, input int off,
                         input logic [31:0] base, input int mode, input bit coll);
      int beats = 0;
      int guard = 0;
      int dn = 0;
      bit acc;
      logic [31:0] old0;
      refill_way    = 2'(w);
      refill_index  = 8'(idx);
      refill_offset = 3'(off);
      refill_start  = 1'b1;
      step();
      refill_start  = 1'b0;
      dn += int'(a_done);
      while (beats < 8 && guard < 100) begin
         case (mode)
            0:       refill_valid = 1'b1;
            1:       refill_valid = (guard % 2 == 0);
            default: refill_valid = 1'($urandom_range(0, 1));
         endcase
         refill_data = refill_valid ? base + 32'(beats) : $urandom;
         acc = refill_valid && exp_ready;
         if (coll && beats == 0 && acc) begin
            rd_req = 1'b1; rd_index = 8'(idx); rd_offset = 3'(off);
            old0 = m0[0][idx][off];
         end
         step();
         if (coll && beats == 0 && acc) begin
            rd_req = 1'b0;
            chk("collide_way1", 128'(a_rd_data[63:32]), 128'(base));
            chk("collide_way0", 128'(a_rd_data[31:0]), 128'(old0));
         end
         if (acc) beats++;
         guard++;
         dn += int'(a_done);
      end
      chk("refill_beats", 128'(beats), 128'(8));
      // Beats offered while not ready must be ignored.
      refill_valid = 1'b1;
      refill_data  = $urandom;
      step();
      dn += int'(a_done);
      step();
      dn += int'(a_done);
      refill_valid = 1'b0;
      chk("done_pulses", 128'(dn), 128'(1));
   endtask

   initial begin
      rst_i = 1'b1; rd_req = 1'b0; rd_index = '0; rd_offset = '0;
      refill_start = 1'b0; refill_way = '0; refill_index = '0; refill_offset = '0;
      refill_valid = 1'b0; refill_data = '0;
      cur_way = 0; cur_idx = 0;
      exp_ready = 0; exp_busy = 0; exp_done = 0;
      exp_av = 0; exp_ad = '0; exp_akn = '1;
      exp_bv = 0; exp_bd = '0; exp_bkn = '1;
      b_p_v = 0; b_p_d = '0; b_p_kn = '0;

      repeat (3) step();
      rst_i = 1'b0;
      step();

      // First read after reset.
      rd_req = 1'b1; rd_index = 8'd0; rd_offset = 3'd0;
      step();
      chk("first_rd_valid", 128'(a_rd_valid), 128'(1));
      rd_req = 1'b0;
      step();
      step();

      // Fill sets 0..7 of every way with concurrent random reads.
      rand_rd = 1;
      for (int w = 0; w < 4; w++)
         for (int i = 0; i < 8; i++)
            refill(w, i, int'($urandom_range(0, 7)), $urandom, 0, 1'b0);
      rand_rd = 0;
      rd_req  = 1'b0;

      // Critical-word-first line: way 1, set 5, starting at word 6.
      refill(1, 5, 6, 32'hA0, 0, 1'b0);
      rd_req = 1'b1; rd_index = 8'd5;
      rd_offset = 3'd6; step(); chk("line_word6", 128'(a_rd_data[63:32]), 128'(32'hA0));
      rd_offset = 3'd7; step(); chk("line_word7", 128'(a_rd_data[63:32]), 128'(32'hA1));
      rd_offset = 3'd0; step(); chk("line_word0", 128'(a_rd_data[63:32]), 128'(32'hA2));
      rd_offset = 3'd5; step(); chk("line_word5", 128'(a_rd_data[63:32]), 128'(32'hA7));
      rd_req = 1'b0;
      step();

      // Toggling valid.
      refill(0, 6, 2, 32'hB000_0000, 1, 1'b0);

      // Write-first collision on set 5 word 3, way 1.
      refill(1, 5, 3, 32'hDEAD_BEEF, 0, 1'b1);

      // Reset in the middle of a refill.
      refill_way = 2'd2; refill_index = 8'd3; refill_offset = 3'd1; refill_start = 1'b1;
      step();
      refill_start = 1'b0;
      refill_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         refill_data = 32'hC000_0000 + 32'(k);
         step();
      end
      refill_valid = 1'b0;
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("rst_busy", 128'(a_busy), 128'(0));
      chk("rst_done", 128'(a_done), 128'(0));
      refill(3, 2, 5, $urandom, 0, 1'b0);

      // Random refills with random beat gaps and random reads.
      rand_rd = 1;
      for (int n = 0; n < 20; n++)
         refill(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 2)), 1'b0);

      // Reads on every cycle, including across a refill.
      rand_rd = 2;
      repeat (20) step();
      refill(2, 4, 7, $urandom, 2, 1'b0);
      repeat (10) step();
      rand_rd = 0;
      rd_req = 1'b0;
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
